traffic_generator_gmii_tx_engine: RTL and testbench
===================================================

// Module: traffic_generator_gmii_tx_engine
// PURPOSE
// Transmit engine of the GMII traffic generator; sits directly downstream of the CPU register block.
// Holds the frame template in a 32-bit-wide buffer loaded through the register block's write port.
// Replays the template as GMII frames (preamble, SFD, data) with programmed gap, burst and count.
// Returns the sent-frame counter to the register block.
// PARAMETERS
// C_FRAME_BUF_ADDRESS_WIDTH  9   buffer depth = 2**AW words of 32 bits (AW=9: 512 words, 2048 bytes)
// C_MIN_IFG                  12  minimum gap in idle byte-times; smaller programmed gaps are raised to it
// PORTS
// clk                   in   1     single clock, 125 MHz GMII TX domain
// reset                 in   1     synchronous, active-high
// control_reg           in   32    bit0 = enable; other bits ignored
// interframe_gap_reg    in   32    idle cycles between frames inside a burst
// interburst_gap_reg    in   32    idle cycles after the last frame of a burst
// frames_per_burst_reg  in   32    frames per burst; 0 = unbounded burst (always interframe gap)
// total_frames_reg      in   64    frames to send; 0 = continuous
// frame_size_reg        in   16    template bytes per frame
// frame_buf_data        in   32    buffer write data; byte0 = [31:24]
// frame_buf_address     in   AW    buffer write word address
// frame_buf_wr          in   1     buffer write strobe, one word per cycle high
// gmii_txd              out  8     GMII transmit data
// gmii_tx_en            out  1     GMII transmit enable
// gmii_tx_er            out  1     GMII transmit error; always 0
// pkts_reg              out  64    frames completed since the last start
// busy                  out  1     1 in any state except IDLE/DONE
// BEHAVIOUR
// - Reset values: gmii_txd=0, gmii_tx_en=0, gmii_tx_er=0, pkts_reg=0, busy=0, state=IDLE.
// - Buffer contents are not reset.
// - Reset mid-frame: gmii_tx_en=0 after the reset edge. The truncated frame is not counted.
// - Buffer: simple dual-port; write on frame_buf_wr; registered read, 1-cycle latency.
// - Byte order out of each word: [31:24], [23:16], [15:8], [7:0].
// - States: IDLE -> PREAMBLE -> DATA [-> FCS] -> GAP -> PREAMBLE | IDLE | DONE.
// - IDLE: on control_reg[0]=1 and frame_size_reg!=0, go to PREAMBLE.
//   - On that edge, pkts_reg, the burst counter and the total counter clear.
//   - gmii_tx_en rises on the next edge, so latency = 2 edges from enable being sampled.
// - PREAMBLE: 7 x 0x55, then 0xD5 (8 cycles).
//   - frame_size_reg is latched on the first preamble cycle; later changes affect only the next frame.
//   - Buffer word 0 is prefetched here.
// - Size rules:
//   - Latched size above 4*2**AW is clamped to 4*2**AW.
//   - Size 0 at latch time returns to IDLE without asserting gmii_tx_en.
// - DATA: exactly latched-size bytes, gmii_tx_en=1 throughout; no bubbles between bytes.
// - Buffer writes during DATA are permitted: the byte sent reflects the memory at read time.
// - Frame end: gmii_tx_en=0 on the cycle after the last byte. pkts_reg increments by 1 on that same edge.
// - GAP length: G = max(C_MIN_IFG, selected gap) cycles with gmii_tx_en=0, gmii_txd=0.
//   - Selected gap = interburst_gap_reg if the burst count has reached frames_per_burst_reg (count then resets).
//   - Otherwise selected gap = interframe_gap_reg.
// - GAP exit:
//   - total_frames_reg!=0 and pkts_reg==total_frames_reg -> DONE.
//   - control_reg[0]=0 -> IDLE.
//   - Otherwise -> PREAMBLE.
// - Enable drop mid-frame: the current frame completes, including its gap, then IDLE; never truncated.
// - DONE: outputs idle and pkts_reg held. Leave DONE for IDLE when control_reg[0]=0.
// - Arithmetic: gap, burst and total counters are 32/32/64-bit unsigned. pkts_reg wraps at 2**64-1 to 0.
// CONFIGURATION
// TRAFFIC_GENERATOR_GMII_FCS_EN
// - Defined: CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected, final inverted) over DATA bytes.
//   - FCS state follows DATA and sends 4 FCS bytes, LSB first.
//   - Frame on wire = 8 + size + 4 bytes; the gap starts after the FCS.
// - Undefined: no FCS state; the template must already contain the FCS. Frame on wire = 8 + size bytes.
// TESTING
// T1 load words 0x00112233,0x44556677; size=8, ifg=12, total=1, enable=1
//    -> 55x7 D5 00 11 22 33 44 55 66 77 (+FCS if _EN); pkts_reg=1; DONE; busy=0
// T2 size=64, total=0, fpb=3, ifg=20, ibg=100 -> idle runs: 20,20,100,20,20,100 cycles, measured tx_en low to high
// T3 ifg=0 -> gap is exactly 12 cycles; size=5000 with AW=9 -> 2048 data bytes sent
// T4 enable dropped during DATA byte 10 of 64 -> all 64 bytes sent, then IDLE; pkts_reg increments once
// T5 reset asserted during DATA -> tx_en=0 the next cycle, pkts_reg=0; re-enable -> clean preamble
// T6 frame_size_reg changed 64->128 mid-frame -> current frame 64 bytes, next frame 128 bytes

Source files
------------

// File: rtl/traffic_generator_gmii_tx_engine_if.sv
// rtl/traffic_generator_gmii_tx_engine_if.sv - GMII transmit bus between the TX engine and the PHY side
interface traffic_generator_gmii_tx_engine_if;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;

    modport master (output gmii_txd, output gmii_tx_en, output gmii_tx_er);
    modport slave  (input  gmii_txd, input  gmii_tx_en, input  gmii_tx_er);
endinterface

// File: rtl/traffic_generator_gmii_tx_engine.sv
// rtl/traffic_generator_gmii_tx_engine.sv - GMII frame replay engine; TRAFFIC_GENERATOR_GMII_FCS_EN appends CRC-32
module traffic_generator_gmii_tx_engine #(
    parameter int C_FRAME_BUF_ADDRESS_WIDTH = 9,
    parameter int C_MIN_IFG                 = 12
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [31:0]                          control_reg,
    input  logic [31:0]                          interframe_gap_reg,
    input  logic [31:0]                          interburst_gap_reg,
    input  logic [31:0]                          frames_per_burst_reg,
    input  logic [63:0]                          total_frames_reg,
    input  logic [15:0]                          frame_size_reg,
    input  logic [31:0]                          frame_buf_data,
    input  logic [C_FRAME_BUF_ADDRESS_WIDTH-1:0] frame_buf_address,
    input  logic                                 frame_buf_wr,
    traffic_generator_gmii_tx_engine_if.master   gmii,
    output logic [63:0]                          pkts_reg,
    output logic                                 busy
);
    localparam int          AW        = C_FRAME_BUF_ADDRESS_WIDTH;
    localparam logic [31:0] MAX_BYTES = 32'(4 * (2 ** AW));
    // A zero-length gap would never terminate the gap counter, so one cycle is the floor.
    localparam logic [31:0] MIN_GAP   = (C_MIN_IFG < 1) ? 32'd1 : 32'(C_MIN_IFG);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
        FCS,
`endif
        GAP,
        DONE
    } state_t;

    state_t       state, state_next;
    logic [31:0]  cnt, cnt_next;
    logic [31:0]  size_q, gap_len, burst_cnt;
    logic [31:0]  burst_inc, gap_sel, gap_next, size_clamped;
    logic         burst_hit, start, enter_gap;
    logic [63:0]  pkts_after;
    logic [7:0]   txd_q, txd_next, data_byte;
    logic         tx_en_q, tx_en_next;
    logic [31:0]  mem [0:(2**AW)-1];
    logic [31:0]  rd_data;
    logic [AW-1:0] rd_addr;
    logic         unused_bits;

    assign unused_bits = ^control_reg[31:1];

    assign burst_inc    = burst_cnt + 32'd1;
    assign burst_hit    = (frames_per_burst_reg != 32'd0) && (burst_inc >= frames_per_burst_reg);
    assign gap_sel      = burst_hit ? interburst_gap_reg : interframe_gap_reg;
    assign gap_next     = (gap_sel < MIN_GAP) ? MIN_GAP : gap_sel;
    assign size_clamped = ({16'd0, frame_size_reg} > MAX_BYTES) ? MAX_BYTES : {16'd0, frame_size_reg};
    // The frame counter bumps on the first gap cycle, so look ahead when deciding the exit on that cycle.
    assign pkts_after   = (cnt == 32'd0) ? pkts_reg + 64'd1 : pkts_reg;

    // Address the word holding the byte after the current one; preamble prefetches word 0.
    assign rd_addr = (state == DATA) ? AW'((cnt + 32'd1) >> 2) : '0;

    // Template buffer: write port from the register block, registered read for the replay side.
    always_ff @(posedge clk) begin
        if (frame_buf_wr) begin
            mem[frame_buf_address] <= frame_buf_data;
        end
        rd_data <= mem[rd_addr];
    end

    // Pick the byte lane of the prefetched word, most significant byte first.
    always_comb begin
        data_byte = rd_data[31:24];
        case (cnt[1:0])
            2'd1:    data_byte = rd_data[23:16];
            2'd2:    data_byte = rd_data[15:8];
            2'd3:    data_byte = rd_data[7:0];
            default: data_byte = rd_data[31:24];
        endcase
    end

`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
    logic [31:0] crc_q;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs_word = ~crc_q;

    // FCS goes out least significant byte first.
    always_comb begin
        fcs_byte = fcs_word[7:0];
        case (cnt[1:0])
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            2'd3:    fcs_byte = fcs_word[31:24];
            default: fcs_byte = fcs_word[7:0];
        endcase
    end

    // Running CRC over the data bytes as they are put on the wire.
    always_ff @(posedge clk) begin
        if (state == PREAMBLE) begin
            crc_q <= 32'hFFFF_FFFF;
        end else if (state == DATA) begin
            crc_q <= crc_step(crc_q, data_byte);
        end
    end
`endif

    // State register and shared phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state and next wire byte; wire outputs are registered one cycle behind the state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 32'd1;
        txd_next   = 8'h00;
        tx_en_next = 1'b0;
        start      = 1'b0;
        enter_gap  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (control_reg[0] && (frame_size_reg != 16'd0)) begin
                    state_next = PREAMBLE;
                    start      = 1'b1;
                end
            end
            PREAMBLE: begin
                if ((cnt == 32'd0) && (frame_size_reg == 16'd0)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    tx_en_next = 1'b1;
                    txd_next   = (cnt == 32'd7) ? 8'hD5 : 8'h55;
                    if (cnt == 32'd7) begin
                        state_next = DATA;
                        cnt_next   = '0;
                    end
                end
            end
            DATA: begin
                tx_en_next = 1'b1;
                txd_next   = data_byte;
                if (cnt == size_q - 32'd1) begin
                    cnt_next = '0;
`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
                    state_next = FCS;
`else
                    state_next = GAP;
                    enter_gap  = 1'b1;
`endif
                end
            end
`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
            FCS: begin
                tx_en_next = 1'b1;
                txd_next   = fcs_byte;
                if (cnt == 32'd3) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    enter_gap  = 1'b1;
                end
            end
`endif
            GAP: begin
                if (cnt == gap_len - 32'd1) begin
                    cnt_next = '0;
                    if ((total_frames_reg != 64'd0) && (pkts_after == total_frames_reg)) begin
                        state_next = DONE;
                    end else if (!control_reg[0]) begin
                        state_next = IDLE;
                    end else begin
                        state_next = PREAMBLE;
                    end
                end
            end
            DONE: begin
                cnt_next = '0;
                if (!control_reg[0]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Wire registers, frame/burst counters, latched size and gap length.
    always_ff @(posedge clk) begin
        if (reset) begin
            txd_q     <= '0;
            tx_en_q   <= 1'b0;
            pkts_reg  <= '0;
            burst_cnt <= '0;
            size_q    <= '0;
            gap_len   <= MIN_GAP;
        end else begin
            txd_q   <= txd_next;
            tx_en_q <= tx_en_next;
            if (start) begin
                pkts_reg  <= '0;
                burst_cnt <= '0;
            end else if ((state == GAP) && (cnt == 32'd0)) begin
                pkts_reg <= pkts_reg + 64'd1;
            end
            if ((state == PREAMBLE) && (cnt == 32'd0)) begin
                size_q <= size_clamped;
            end
            if (enter_gap) begin
                gap_len   <= gap_next;
                burst_cnt <= burst_hit ? 32'd0 : burst_inc;
            end
        end
    end

    assign gmii.gmii_txd   = txd_q;
    assign gmii.gmii_tx_en = tx_en_q;
    assign gmii.gmii_tx_er = 1'b0;
    assign busy            = (state != IDLE) && (state != DONE);
endmodule

// File: tb/tb_traffic_generator_gmii_tx_engine.sv
// tb/tb_traffic_generator_gmii_tx_engine.sv - self-checking bench for the GMII TX engine
module tb_traffic_generator_gmii_tx_engine;
    localparam int AW     = 9;
    localparam int NBYTES = 4 * (2 ** AW);
`ifdef TRAFFIC_GENERATOR_GMII_FCS_EN
    localparam int FCS_LEN = 4;
`else
    localparam int FCS_LEN = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   control_reg, interframe_gap_reg, interburst_gap_reg, frames_per_burst_reg;
    logic [63:0]   total_frames_reg;
    logic [15:0]   frame_size_reg;
    logic [31:0]   frame_buf_data;
    logic [AW-1:0] frame_buf_address;
    logic          frame_buf_wr;
    logic [63:0]   pkts_reg;
    logic          busy;

    traffic_generator_gmii_tx_engine_if gmii ();

    traffic_generator_gmii_tx_engine #(
        .C_FRAME_BUF_ADDRESS_WIDTH(AW),
        .C_MIN_IFG(12)
    ) dut (
        .clk(clk),
        .reset(reset),
        .control_reg(control_reg),
        .interframe_gap_reg(interframe_gap_reg),
        .interburst_gap_reg(interburst_gap_reg),
        .frames_per_burst_reg(frames_per_burst_reg),
        .total_frames_reg(total_frames_reg),
        .frame_size_reg(frame_size_reg),
        .frame_buf_data(frame_buf_data),
        .frame_buf_address(frame_buf_address),
        .frame_buf_wr(frame_buf_wr),
        .gmii(gmii),
        .pkts_reg(pkts_reg),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] tmpl [NBYTES];
    logic [7:0] cur [$];
    logic [7:0] last_frame [$];
    int         len_q [$];
    int         gap_q [$];
    int         low_run = 0;
    int         mon_cur_len = 0;
    bit         seen = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_fcs(input int len);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ tmpl[i][b];
                c  = {1'b0, c[31:1]};
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic int model_gap(input int k, input int ifg, input int ibg, input int fpb);
        int g;
        g = ((fpb != 0) && ((k % fpb) == 0)) ? ibg : ifg;
        return (g < 12) ? 12 : g;
    endfunction

    task automatic check_frame();
        int          n, dlen, bad;
        logic [31:0] f;
        n    = cur.size();
        dlen = n - 8 - FCS_LEN;
        bad  = 0;
        for (int i = 0; i < 8 && i < n; i++) begin
            if (cur[i] !== ((i == 7) ? 8'hD5 : 8'h55)) bad++;
        end
        if (dlen < 0) begin
            bad++;
        end else begin
            for (int i = 0; i < dlen; i++) begin
                if (cur[8 + i] !== tmpl[i]) bad++;
            end
            if (FCS_LEN != 0) begin
                f = ref_fcs(dlen);
                for (int j = 0; j < 4; j++) begin
                    if (cur[8 + dlen + j] !== f[8 * j +: 8]) bad++;
                end
            end
        end
        check("frame_content", 64'(bad), 64'd0);
        len_q.push_back(dlen);
        last_frame = cur;
    endtask

    // Wire monitor: collects frames, checks their bytes, records idle runs between frames.
    always @(negedge clk) begin
        if (reset) begin
            cur.delete();
            seen    = 1'b0;
            low_run = 0;
        end else if (gmii.gmii_tx_en) begin
            if ((cur.size() == 0) && seen) gap_q.push_back(low_run);
            cur.push_back(gmii.gmii_txd);
        end else begin
            if (cur.size() != 0) begin
                check_frame();
                seen    = 1'b1;
                low_run = 0;
                cur.delete();
            end
            low_run++;
        end
        mon_cur_len = cur.size();
    end

    task automatic clear_mon();
        len_q.delete();
        gap_q.delete();
        seen    = 1'b0;
        low_run = 0;
    endtask

    task automatic write_word(input int addr, input logic [31:0] data);
        frame_buf_wr      = 1'b1;
        frame_buf_address = AW'(addr);
        frame_buf_data    = data;
        for (int b = 0; b < 4; b++) tmpl[4 * addr + b] = data[31 - 8 * b -: 8];
        tick();
        frame_buf_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && (t < 20000)) begin
            tick();
            t++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while ((len_q.size() < n) && (t < 20000)) begin
            tick();
            t++;
        end
        check("wait_frames", 64'(len_q.size() < n), 64'd0);
    endtask

    task automatic wait_bytes(input int n);
        int t = 0;
        while ((mon_cur_len < n) && (t < 20000)) begin
            tick();
            t++;
        end
        check("wait_bytes", 64'(mon_cur_len < n), 64'd0);
    endtask

    task automatic set_regs(input int size, input int ifg, input int ibg, input int fpb, input int total);
        frame_size_reg       = 16'(size);
        interframe_gap_reg   = 32'(ifg);
        interburst_gap_reg   = 32'(ibg);
        frames_per_burst_reg = 32'(fpb);
        total_frames_reg     = 64'(total);
    endtask

    task automatic run_config(input int size, input int ifg, input int ibg, input int fpb,
                              input int total, input int exp_len, input int exp_pkts);
        set_regs(size, ifg, ibg, fpb, total);
        clear_mon();
        control_reg = 32'd1;
        tick();
        wait_idle("run_done");
        check("run_pkts", pkts_reg, 64'(exp_pkts));
        check("run_nframes", 64'(len_q.size()), 64'(total));
        foreach (len_q[i]) check("run_len", 64'(len_q[i]), 64'(exp_len));
        check("run_ngaps", 64'(gap_q.size()), 64'(total - 1));
        foreach (gap_q[i]) check("run_gap", 64'(gap_q[i]), 64'(model_gap(i + 1, ifg, ibg, fpb)));
        control_reg = 32'd0;
        tick();
        tick();
    endtask

    typedef struct {
        int size;
        int ifg;
        int ibg;
        int fpb;
        int total;
        int exp_len;
        int exp_pkts;
    } vec_t;

    initial begin
        vec_t       tbl [5];
        logic [7:0] t1_exp [8];
        int         sz, ig, bg, fb, tot;

        tbl[0] = '{8, 12, 0, 0, 1, 8, 1};
        tbl[1] = '{64, 20, 100, 3, 6, 64, 6};
        tbl[2] = '{5000, 0, 0, 0, 2, 2048, 2};
        tbl[3] = '{1, 5, 13, 2, 3, 1, 3};
        tbl[4] = '{2048, 30, 0, 1, 2, 2048, 2};
        t1_exp = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

        reset = 1'b1;
        control_reg = 32'd0;
        set_regs(0, 0, 0, 0, 0);
        frame_buf_data = 32'd0;
        frame_buf_address = '0;
        frame_buf_wr = 1'b0;
        tick();
        tick();
        tick();
        check("rst_txd", 64'(gmii.gmii_txd), 64'd0);
        check("rst_tx_en", 64'(gmii.gmii_tx_en), 64'd0);
        check("rst_tx_er", 64'(gmii.gmii_tx_er), 64'd0);
        check("rst_pkts", pkts_reg, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        for (int a = 0; a < 2 ** AW; a++) write_word(a, $urandom());

        // Two-word template, single frame: latency and exact bytes.
        write_word(0, 32'h0011_2233);
        write_word(1, 32'h4455_6677);
        set_regs(8, 12, 0, 0, 1);
        clear_mon();
        control_reg = 32'd1;
        tick();
        check("t1_lat_txen_low", 64'(gmii.gmii_tx_en), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        tick();
        check("t1_lat_txen_high", 64'(gmii.gmii_tx_en), 64'd1);
        check("t1_first_byte", 64'(gmii.gmii_txd), 64'h55);
        wait_idle("t1_done");
        check("t1_pkts", pkts_reg, 64'd1);
        check("t1_nframes", 64'(len_q.size()), 64'd1);
        check("t1_wire_len", 64'(last_frame.size()), 64'(16 + FCS_LEN));
        if (last_frame.size() >= 16) begin
            for (int i = 0; i < 8; i++) check("t1_byte", 64'(last_frame[8 + i]), 64'(t1_exp[i]));
        end
        control_reg = 32'd0;
        tick();
        tick();

        for (int v = 0; v < 5; v++) begin
            run_config(tbl[v].size, tbl[v].ifg, tbl[v].ibg, tbl[v].fpb, tbl[v].total,
                       tbl[v].exp_len, tbl[v].exp_pkts);
        end

        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < 32; a++) write_word(a, $urandom());
            sz  = int'($urandom_range(1, 100));
            ig  = int'($urandom_range(0, 30));
            bg  = int'($urandom_range(0, 40));
            fb  = int'($urandom_range(0, 3));
            tot = int'($urandom_range(1, 5));
            run_config(sz, ig, bg, fb, tot, sz, tot);
        end

        // Enable dropped mid-frame: the frame and its gap finish, then idle.
        set_regs(64, 12, 0, 0, 0);
        clear_mon();
        control_reg = 32'd1;
        tick();
        wait_bytes(18);
        control_reg = 32'd0;
        wait_idle("t4_done");
        check("t4_nframes", 64'(len_q.size()), 64'd1);
        if (len_q.size() > 0) check("t4_len", 64'(len_q[0]), 64'd64);
        check("t4_pkts", pkts_reg, 64'd1);
        tick();

        // Reset during the second frame: wire drops at once, count clears, restart is clean.
        set_regs(64, 12, 0, 0, 0);
        clear_mon();
        control_reg = 32'd1;
        tick();
        wait_frames(1);
        wait_bytes(20);
        reset = 1'b1;
        tick();
        check("t5_tx_en", 64'(gmii.gmii_tx_en), 64'd0);
        check("t5_pkts", pkts_reg, 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        clear_mon();
        wait_frames(1);
        control_reg = 32'd0;
        wait_idle("t5_done");
        check("t5_nframes", 64'(len_q.size()), 64'd1);
        if (len_q.size() > 0) check("t5_len", 64'(len_q[0]), 64'd64);
        check("t5_pkts_after", pkts_reg, 64'd1);
        tick();

        // Size changed mid-frame only affects the next frame.
        set_regs(64, 12, 0, 0, 2);
        clear_mon();
        control_reg = 32'd1;
        tick();
        wait_bytes(30);
        frame_size_reg = 16'd128;
        wait_idle("t6_done");
        check("t6_nframes", 64'(len_q.size()), 64'd2);
        if (len_q.size() > 1) begin
            check("t6_len0", 64'(len_q[0]), 64'd64);
            check("t6_len1", 64'(len_q[1]), 64'd128);
        end
        check("t6_pkts", pkts_reg, 64'd2);
        control_reg = 32'd0;
        tick();
        tick();

        // Size zeroed between frames: engine returns to idle without another frame.
        set_regs(16, 12, 0, 0, 0);
        clear_mon();
        control_reg = 32'd1;
        tick();
        wait_frames(1);
        frame_size_reg = 16'd0;
        wait_idle("zsize_done");
        check("zsize_nframes", 64'(len_q.size()), 64'd1);
        check("zsize_tx_en", 64'(gmii.gmii_tx_en), 64'd0);
        check("zsize_pkts", pkts_reg, 64'd1);
        control_reg = 32'd0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
